// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command front-end for the 8-bit combinational ALU. Commands arrive on a
//   valid/ready port and are queued in a DEPTH-entry FIFO. A three-state FSM
//   (IDLE -> EXEC -> RESP) pops one command at a time. It drives registered
//   operands into the ALU, writes the result and flags back into the
//   accumulator, and holds a response until the consumer takes it.
//
//   Optional feature: define ALU_CMD_CNT_EN to add cmd_count, a 16-bit
//   wrapping count of response handshakes.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = FIFO not full)
//   cmd_load                  1: load cmd_operand into ACC, no ALU op
//   cmd_op, cmd_operand       opcode and operand b
//   alu_a, alu_b, alu_op      registered ALU inputs (a = ACC snapshot)
//   alu_y, alu_carry,
//   alu_overflow, alu_zero    ALU result and status
//   res_valid/res_ready       response handshake
//   res_data, res_flags       ACC after the command, {div0, overflow, carry}
//   acc                       current accumulator
//   err_div0                  sticky divide-by-zero error
//   cmd_count                 response count (ALU_CMD_CNT_EN only)
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_load,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_operand,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_y,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [2:0]  res_flags,
    output logic [7:0]  acc,
`ifdef ALU_CMD_CNT_EN
    output logic [15:0] cmd_count,
`endif
    output logic        err_div0
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                  state_q;
    logic [DEPTH-1:0]        mem_load_q;
    logic [DEPTH-1:0][3:0]   mem_op_q;
    logic [DEPTH-1:0][7:0]   mem_opnd_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic                    cur_load_q;
    logic [7:0]              cur_opnd_q;
    logic [7:0]              acc_q, alu_a_q, alu_b_q, res_data_q;
    logic [3:0]              alu_op_q;
    logic [2:0]              res_flags_q;
    logic                    res_valid_q, err_div0_q;
`ifdef ALU_CMD_CNT_EN
    logic [15:0]             cnt_q;
`endif

    logic       empty, full, push;
    logic       head_load;
    logic [3:0] head_op;
    logic [7:0] head_opnd;
    logic [7:0] acc_d;
    logic [2:0] flags_d;
    logic       div0_d;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // No bypass: a pop in the same cycle does not open a full FIFO.
    assign push  = cmd_valid && !full;

    assign head_load = mem_load_q[rd_ptr_q[AW-1:0]];
    assign head_op   = mem_op_q[rd_ptr_q[AW-1:0]];
    assign head_opnd = mem_opnd_q[rd_ptr_q[AW-1:0]];

    assign cmd_ready = !full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;
    assign acc       = acc_q;
    assign err_div0  = err_div0_q;
`ifdef ALU_CMD_CNT_EN
    assign cmd_count = cnt_q;
`endif

    // FIFO storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_load_q[wr_ptr_q[AW-1:0]] <= cmd_load;
            mem_op_q[wr_ptr_q[AW-1:0]]   <= cmd_op;
            mem_opnd_q[wr_ptr_q[AW-1:0]] <= cmd_operand;
        end
    end

    // Writeback in EXEC. alu_op_q holds the opcode of the command in
    // flight, because load commands leave the ALU inputs untouched.
    always_comb begin
        acc_d   = alu_y;
        flags_d = 3'b000;
        div0_d  = 1'b0;
        if (cur_load_q) begin
            acc_d = cur_opnd_q;
        end else if (alu_op_q == 4'd3 && alu_zero) begin
            acc_d   = acc_q;
            flags_d = 3'b100;
            div0_d  = 1'b1;
        end else begin
            case (alu_op_q)
                4'd0, 4'd1, 4'd8, 4'd9: flags_d = {2'b00, alu_carry};
                4'd2:                   flags_d = {1'b0, alu_overflow, 1'b0};
                default:                flags_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cur_load_q  <= 1'b0;
            cur_opnd_q  <= '0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
            err_div0_q  <= 1'b0;
`ifdef ALU_CMD_CNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        rd_ptr_q   <= rd_ptr_q + PW'(1);
                        cur_load_q <= head_load;
                        cur_opnd_q <= head_opnd;
                        if (!head_load) begin
                            alu_a_q  <= acc_q;
                            alu_b_q  <= head_opnd;
                            alu_op_q <= head_op;
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    acc_q       <= acc_d;
                    res_data_q  <= acc_d;
                    res_flags_q <= flags_d;
                    if (div0_d) err_div0_q <= 1'b1;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
`ifdef ALU_CMD_CNT_EN
                        cnt_q       <= cnt_q + 16'd1;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer. It contains a stand-in combinational ALU
// and a sequential reference of the command semantics. Directed scenarios run
// first, then a randomized run with random backpressure.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_load = 1'b0;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  cmd_operand = '0;
    logic [7:0]  alu_a, alu_b, alu_y;
    logic [3:0]  alu_op;
    logic        alu_carry, alu_overflow, alu_zero;
    logic        res_valid, res_ready = 1'b0;
    logic [7:0]  res_data, acc;
    logic [2:0]  res_flags;
    logic        err_div0;
`ifdef ALU_CMD_CNT_EN
    logic [15:0] cmd_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  acc_m;
    logic        err_m;
    logic [10:0] exp_q[$];

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .acc(acc),
`ifdef ALU_CMD_CNT_EN
        .cmd_count(cmd_count),
`endif
        .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: {zero, overflow, carry, y}. Carry and overflow are driven
    // for every op so the sequencer's flag masking is actually exercised.
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  y;
        logic        c, ov, z;
        s  = {1'b0, a} + {1'b0, b};
        p  = {8'd0, a} * {8'd0, b};
        c  = s[8];
        ov = |p[15:8];
        z  = (b == 8'd0);
        case (op)
            4'd0:  y = s[7:0];
            4'd1:  begin y = a - b; c = (a < b); end
            4'd2:  y = p[7:0];
            4'd3:  y = z ? 8'd0 : a / b;
            4'd4:  y = a & b;
            4'd5:  y = a | b;
            4'd6:  y = a ^ b;
            4'd7:  y = ~a;
            4'd8:  begin y = {a[6:0], 1'b0}; c = a[7]; end
            4'd9:  begin y = {1'b0, a[7:1]}; c = a[0]; end
            4'd10: y = {7'd0, a == b};
            4'd11: y = {7'd0, a > b};
            4'd12: y = {7'd0, a < b};
            4'd13: y = {7'd0, a != b};
            4'd14: y = b;
            default: y = a;
        endcase
        return {z, ov, c, y};
    endfunction

    always_comb {alu_zero, alu_overflow, alu_carry, alu_y} = alu_f(alu_a, alu_b, alu_op);

    // Reference: applies one command to the model accumulator and returns
    // the expected {flags, data} of its response.
    function automatic logic [10:0] ref_step(input logic l, input logic [3:0] op,
                                             input logic [7:0] b);
        logic [10:0] r;
        logic [2:0]  f;
        f = 3'b000;
        if (l) begin
            acc_m = b;
        end else begin
            r = alu_f(acc_m, b, op);
            if (op == 4'd3 && b == 8'd0) begin
                f = 3'b100;
                err_m = 1'b1;
            end else begin
                acc_m = r[7:0];
                if (op == 4'd0 || op == 4'd1 || op == 4'd8 || op == 4'd9) f = {2'b00, r[8]};
                else if (op == 4'd2) f = {1'b0, r[9], 1'b0};
            end
        end
        return {f, acc_m};
    endfunction

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic push(input logic l, input logic [3:0] op, input logic [7:0] b,
                        input int lim, output bit ok);
        logic rdy;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_load = l; cmd_op = op; cmd_operand = b;
        for (int k = 0; k < lim; k++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [7:0] d, output logic [2:0] f);
        bit got;
        got = 1'b0; d = 'x; f = 'x;
        res_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (res_valid) begin
                d = res_data; f = res_flags; got = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL resp_timeout: got no response, required one within 20 cycles");
        end
    endtask

    task automatic run_cmd(input logic l, input logic [3:0] op, input logic [7:0] b,
                           output logic [7:0] d, output logic [2:0] f);
        bit ok;
        push(l, op, b, 20, ok);
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: command not accepted, required acceptance");
        end
        wait_resp(d, f);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b required 0", res_valid); end
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
        n_chk++; if ({acc, alu_a, alu_b, alu_op} !== 28'd0) begin n_fail++; $display("FAIL rst_regs: acc=%h a=%h b=%h op=%h required 0", acc, alu_a, alu_b, alu_op); end
        n_chk++; if ({res_data, res_flags, err_div0} !== 12'd0) begin n_fail++; $display("FAIL rst_resp: data=%h flags=%b err=%b required 0", res_data, res_flags, err_div0); end
    endtask

    task automatic test_load_add();
        logic [7:0] d; logic [2:0] f; bit ok;
        run_cmd(1'b1, 4'd0, 8'd250, d, f);
        n_chk++; if ({f, d} !== {3'b000, 8'd250}) begin n_fail++; $display("FAIL load250: got %0d/%b required 250/000", d, f); end
        push(1'b0, 4'd0, 8'd10, 20, ok);
        @(posedge clk); #1;
        n_chk++; if ({alu_a, alu_b, alu_op} !== {8'd250, 8'd10, 4'd0}) begin n_fail++; $display("FAIL exec_operands: got a=%0d b=%0d op=%0d required 250 10 0", alu_a, alu_b, alu_op); end
        @(posedge clk); #1;
        n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL latency: res_valid got %b required 1", res_valid); end
        wait_resp(d, f);
        n_chk++; if ({f, d} !== {3'b001, 8'd4}) begin n_fail++; $display("FAIL add_carry: got %0d/%b required 4/001", d, f); end
        n_chk++; if (acc !== 8'd4) begin n_fail++; $display("FAIL add_acc: got %0d required 4", acc); end
    endtask

    task automatic test_mul_overflow();
        logic [7:0] d; logic [2:0] f;
        run_cmd(1'b1, 4'd0, 8'd20, d, f);
        run_cmd(1'b0, 4'd2, 8'd20, d, f);
        n_chk++; if ({f, d} !== {3'b010, 8'd144}) begin n_fail++; $display("FAIL mul_ovf: got %0d/%b required 144/010", d, f); end
    endtask

    task automatic test_div0();
        logic [7:0] d; logic [2:0] f;
        run_cmd(1'b1, 4'd0, 8'd9, d, f);
        run_cmd(1'b0, 4'd3, 8'd0, d, f);
        n_chk++; if ({f, d} !== {3'b100, 8'd9}) begin n_fail++; $display("FAIL div0_resp: got %0d/%b required 9/100", d, f); end
        n_chk++; if (err_div0 !== 1'b1) begin n_fail++; $display("FAIL div0_err: got %b required 1", err_div0); end
        run_cmd(1'b0, 4'd0, 8'd1, d, f);
        n_chk++; if ({f, d} !== {3'b000, 8'd10}) begin n_fail++; $display("FAIL after_div0: got %0d/%b required 10/000", d, f); end
        n_chk++; if (err_div0 !== 1'b1) begin n_fail++; $display("FAIL div0_sticky: got %b required 1", err_div0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d; logic [2:0] f; bit ok; int acc_n;
        do_reset();
        acc_n = 0;
        for (int i = 1; i <= 6; i++) begin
            push(1'b1, 4'd0, 8'(i), 4, ok);
            if (ok) acc_n++;
        end
        n_chk++; if (acc_n !== 5) begin n_fail++; $display("FAIL full_accept: got %0d pushes required 5", acc_n); end
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b required 0", cmd_ready); end
        for (int k = 0; k < 3; k++) begin
            n_chk++; if ({res_valid, res_data} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL stall_hold: got v=%b d=%0d required 1/1", res_valid, res_data); end
            @(posedge clk); #1;
        end
        for (int i = 1; i <= 5; i++) begin
            wait_resp(d, f);
            n_chk++; if ({f, d} !== {3'b000, 8'(i)}) begin n_fail++; $display("FAIL order_%0d: got %0d/%b required %0d/000", i, d, f, i); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        res_ready = 1'b0;
        push(1'b1, 4'd0, 8'd77, 20, ok);
        push(1'b1, 4'd0, 8'd1, 20, ok);
        push(1'b1, 4'd0, 8'd2, 20, ok);
        push(1'b1, 4'd0, 8'd3, 20, ok);
        n_chk++; if (acc !== 8'd77) begin n_fail++; $display("FAIL pre_rst_acc: got %0d required 77", acc); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++; if ({res_valid, acc, cmd_ready} !== {1'b0, 8'd0, 1'b1}) begin n_fail++; $display("FAIL mid_rst: got v=%b acc=%0d rdy=%b required 0/0/1", res_valid, acc, cmd_ready); end
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_chk++; if ({res_valid, acc} !== 9'd0) begin n_fail++; $display("FAIL stale_resp: got v=%b acc=%0d required 0/0", res_valid, acc); end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_compare();
        logic [7:0] d; logic [2:0] f;
        do_reset();
        run_cmd(1'b1, 4'd0, 8'd7, d, f);
        run_cmd(1'b0, 4'd11, 8'd3, d, f);
        n_chk++; if ({f, d} !== {3'b000, 8'd1}) begin n_fail++; $display("FAIL cmp_gt: got %0d/%b required 1/000", d, f); end
`ifdef ALU_CMD_CNT_EN
        n_chk++; if (cmd_count !== 16'd2) begin n_fail++; $display("FAIL cmd_count: got %0d required 2", cmd_count); end
`endif
    endtask

    task automatic test_random();
        localparam int N = 60;
        do_reset();
        acc_m = '0; err_m = 1'b0; exp_q.delete();
        fork
            begin : producer
                bit ok; logic l; logic [3:0] op; logic [7:0] b;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    l  = ($urandom_range(0, 3) == 0);
                    op = 4'($urandom_range(0, 15));
                    b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
                    push(l, op, b, 40, ok);
                    if (ok) exp_q.push_back(ref_step(l, op, b));
                    else begin n_chk++; n_fail++; $display("FAIL rnd_push_timeout: command %0d not accepted", i); end
                end
            end
            begin : consumer
                int got; logic r; logic hs;
                got = 0;
                for (int c = 0; c < 3000 && got < N; c++) begin
                    r = ($urandom_range(0, 2) != 0);
                    res_ready = r;
                    hs = res_valid && r;
                    if (res_valid) begin
                        n_chk++;
                        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_unexpected: got %0d/%b with no command outstanding", res_data, res_flags); end
                        else if ({res_flags, res_data} !== exp_q[0]) begin n_fail++; $display("FAIL rnd_resp_%0d: got %0d/%b required %0d/%b", got, res_data, res_flags, exp_q[0][7:0], exp_q[0][10:8]); end
                    end
                    @(posedge clk); #1;
                    if (hs) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        got++;
                    end
                end
                res_ready = 1'b0;
                if (got < N) begin n_chk++; n_fail++; $display("FAIL rnd_timeout: got %0d responses required %0d", got, N); end
            end
        join
        n_chk++; if (acc !== acc_m) begin n_fail++; $display("FAIL rnd_acc: got %0d required %0d", acc, acc_m); end
        n_chk++; if (err_div0 !== err_m) begin n_fail++; $display("FAIL rnd_err: got %b required %b", err_div0, err_m); end
`ifdef ALU_CMD_CNT_EN
        n_chk++; if (cmd_count !== 16'(N)) begin n_fail++; $display("FAIL rnd_count: got %0d required %0d", cmd_count, N); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_mul_overflow();
        test_div0();
        test_backpressure();
        test_reset_mid();
        test_compare();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the 8-bit combinational ALU.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered operands and opcode into the ALU. Operand a is always the internal 8-bit accumulator; operand b is the command operand.
- Captures the ALU result and flags into the accumulator and presents them on a valid/ready response port.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_load  in  1  1 = load cmd_operand into ACC, no ALU op
- cmd_op  in  4  ALU opcode 0..15
- cmd_operand  in  8  operand b
- alu_a  out  8  registered ACC snapshot to ALU
- alu_b  out  8  registered operand to ALU
- alu_op  out  4  registered opcode to ALU
- alu_y  in  8  ALU result
- alu_carry  in  1  ALU carry
- alu_overflow  in  1  ALU multiply overflow
- alu_zero  in  1  ALU divide-by-zero indication
- res_valid  out  1  response held
- res_ready  in  1  consumer accepts response
- res_data  out  8  ACC value after the command
- res_flags  out  3  {div0, overflow, carry} of the command
- acc  out  8  current accumulator
- err_div0  out  1  sticky divide-by-zero error

Behaviour:
- Reset (rst=1 at a clk edge, dominant over all other inputs, including mid-operation):
  - FIFO is emptied and state goes to IDLE.
  - ACC, alu_a, alu_b, alu_op, res_data, res_flags, err_div0 and res_valid all become 0.
  - cmd_ready is 1 in the cycle after reset.
- Command push:
  - A command is pushed when cmd_valid && cmd_ready at a clk edge.
  - cmd_ready = !full. There is no same-cycle bypass when full, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH. Full and empty are tracked with an extra pointer bit.
- FSM states: IDLE, EXEC, RESP.
  - IDLE, FIFO not empty: pop the head entry and go to EXEC.
    - ALU command: alu_a<=ACC, alu_b<=operand, alu_op<=op.
    - Load command: alu_* are unchanged.
  - EXEC, one cycle; the ALU settles combinationally during this cycle. At the end of the cycle:
    - load: ACC<=operand; flags 000.
    - op==3 && alu_zero: ACC unchanged; flags 100; err_div0<=1.
    - op 0,1,8,9: ACC<=alu_y; flags {0,0,alu_carry}.
    - op 2: ACC<=alu_y; flags {0,alu_overflow,0}.
    - all other ops: ACC<=alu_y; flags 000.
    - In every case res_data<=new ACC, res_valid<=1, go to RESP.
  - RESP: res_valid, res_data and res_flags are held stable until res_ready=1 at an edge. Then res_valid<=0 and go to IDLE.
- Latency:
  - A command accepted at edge E into an empty FIFO with the FSM in IDLE pops at E+1 and has res_valid=1 after E+2.
  - Throughput is one command per 3 cycles when res_ready is held high.
- Ordering and state:
  - Commands complete strictly in FIFO order.
  - ACC is only modified in EXEC.
  - Push and pop in the same edge are both honoured; the occupancy count is unchanged.
- err_div0 is sticky and is cleared only by rst.
- Comparisons (ops 10-13) write 0 or 1 into ACC.
- Arithmetic wraps modulo 256. The block performs no arithmetic itself.

Optional Feature:
- Macro: ALU_CMD_CNT_EN.
- Defined:
  - Adds output port cmd_count [15:0], reset to 0.
  - Increments by 1 on every response handshake (res_valid && res_ready) and wraps from 0xFFFF to 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Load and add with carry: reset; push load 250, then op0 operand 10 with res_ready=1 → responses 250/000, then 4/001; acc=4; alu_a=250 and alu_b=10 during EXEC.
- Multiply overflow: load 20, then op2 operand 20 → res_data=144, flags 010.
- Divide by zero: load 9, then op3 operand 0 → res_data=9, flags 100, err_div0=1 and stays 1. A following op0 operand 1 → res_data=10, err_div0 still 1.
- Backpressure and full FIFO, DEPTH=4: res_ready=0; push 6 loads (1..6) → 5 pushes are accepted (4 in FIFO plus 1 popped into EXEC/RESP) and cmd_ready drops. Release res_ready → res_data sequence 1,2,3,4,5 in order; res_data stays stable while stalled.
- Reset mid-operation: assert rst while in EXEC with 2 entries queued → next cycle res_valid=0, acc=0, cmd_ready=1; no stale response appears.
- Comparison and counter: load 7, then op11 operand 3 → res_data=1. With ALU_CMD_CNT_EN defined, cmd_count=2.
